// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the memory access stage and its MEM/WB register.
package mem_access_unit_pkg;

  // Two-state access controller: IDLE accepts new work, BUSY waits for mem_ack.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Default number of BUSY cycles to wait for mem_ack before abandoning the access.
  localparam int DEFAULT_ACK_TIMEOUT = 16;

  // Width of the BUSY-cycle counter; it saturates instead of wrapping.
  localparam int CNT_W = 8;

  // Contents of the MEM/WB pipeline register.
  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic [4:0]  rd;
    logic [31:0] alu_result;
    logic [31:0] read_data;
  } mem_wb_t;

  // A bubble writes nothing back: no RegWrite, no MemtoReg, Rd=0, data cleared.
  localparam mem_wb_t MEM_WB_BUBBLE = '{
    reg_write:  1'b0,
    mem_to_reg: 1'b0,
    rd:         5'd0,
    alu_result: 32'd0,
    read_data:  32'd0
  };

  // Word accesses must sit on a 4-byte boundary.
  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: each edge loads either the presented fields or a bubble.
module mem_wb_reg
  import mem_access_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_bubble,
  input  logic        i_reg_write,
  input  logic        i_mem_to_reg,
  input  logic [4:0]  i_rd,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_read_data,
  output logic        o_reg_write,
  output logic        o_mem_to_reg,
  output logic [4:0]  o_rd,
  output logic [31:0] o_alu_result,
  output logic [31:0] o_read_data
);

  mem_wb_t w_load;
  mem_wb_t r_wb;

  assign w_load = '{
    reg_write:  i_reg_write,
    mem_to_reg: i_mem_to_reg,
    rd:         i_rd,
    alu_result: i_alu_result,
    read_data:  i_read_data
  };

  // Pipeline register: clear on reset, otherwise take a bubble or the new fields.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wb <= '0;
    end else if (i_bubble) begin
      r_wb <= MEM_WB_BUBBLE;
    end else begin
      r_wb <= w_load;
    end
  end

  assign o_reg_write  = r_wb.reg_write;
  assign o_mem_to_reg = r_wb.mem_to_reg;
  assign o_rd         = r_wb.rd;
  assign o_alu_result = r_wb.alu_result;
  assign o_read_data  = r_wb.read_data;

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage controller: issues one registered memory request per access, stalls
// the pipeline until mem_ack or timeout, and feeds the MEM/WB register.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWrite_in,
  input  logic        MemtoReg_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [31:0] ALU_result_in,
  input  logic [31:0] reg_read_data_2_in,
  input  logic [4:0]  EX_MEM_RegisterRd_in,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        MEM_Stall,
  output logic        mem_err,
  output logic        RegWrite_out,
  output logic        MemtoReg_out,
  output logic [31:0] mem_read_data_out,
  output logic [31:0] ALU_result_out,
  output logic [4:0]  MEM_WB_RegisterRd_out
);

  // Counter value seen during the last permitted BUSY cycle.
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_count;

  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_mem_err;

  logic        r_cap_reg_write;
  logic        r_cap_mem_to_reg;
  logic [4:0]  r_cap_rd;

  logic        w_idle;
  logic        w_busy;
  logic        w_access;
  logic        w_aligned;
  logic        w_pass;
  logic        w_start;
  logic        w_misaligned;
  logic        w_ack;
  logic        w_timeout;
  logic        w_hold;

  logic        w_wb_bubble;
  logic        w_wb_reg_write;
  logic        w_wb_mem_to_reg;
  logic [4:0]  w_wb_rd;
  logic [31:0] w_wb_alu_result;
  logic [31:0] w_wb_read_data;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_busy    = (r_state == ST_BUSY);
  assign w_access  = MemRead_in | MemWrite_in;
  assign w_aligned = is_aligned(ALU_result_in);

  // IDLE decisions; mem_ack plays no part here.
  assign w_pass       = w_idle & ~w_access;
  assign w_start      = w_idle & w_access & w_aligned;
  assign w_misaligned = w_idle & w_access & ~w_aligned;

  // BUSY decisions; an ack in the last permitted cycle beats the timeout.
  assign w_ack     = w_busy & mem_ack;
  assign w_timeout = w_busy & ~mem_ack & (r_count >= TIMEOUT_LAST);
  assign w_hold    = w_busy & ~mem_ack & ~w_timeout;

  // Hold upstream while launching or waiting; never while reset is asserted.
  assign MEM_Stall = reset & (w_start | w_hold);

  // Next-state logic: every access returns to IDLE, so back-to-back accesses serialise.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_state_next = ST_BUSY;
      ST_BUSY: if (w_ack || w_timeout) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // BUSY-cycle counter: cleared on launch, counts unacknowledged cycles, saturates.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
    end else if (w_start) begin
      r_count <= '0;
    end else if (w_hold && (r_count != CNT_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Request interface: captured on launch, held while BUSY, request dropped on ack/abort.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_start) begin
      r_mem_req   <= 1'b1;
      r_mem_we    <= MemWrite_in;
      r_mem_addr  <= ALU_result_in;
      r_mem_wdata <= reg_read_data_2_in;
    end else if (w_ack || w_timeout) begin
      r_mem_req   <= 1'b0;
    end
  end

  // Writeback fields of the in-flight access, replayed into MEM/WB on ack.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cap_reg_write  <= 1'b0;
      r_cap_mem_to_reg <= 1'b0;
      r_cap_rd         <= '0;
    end else if (w_start) begin
      r_cap_reg_write  <= RegWrite_in;
      r_cap_mem_to_reg <= MemtoReg_in;
      r_cap_rd         <= EX_MEM_RegisterRd_in;
    end
  end

  // Error pulse: high for exactly the cycle after a misaligned access or a timeout.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mem_err <= 1'b0;
    end else begin
      r_mem_err <= w_misaligned | w_timeout;
    end
  end

  // MEM/WB source select: pass-through, completed access, or bubble otherwise.
  always_comb begin
    w_wb_bubble     = 1'b1;
    w_wb_reg_write  = 1'b0;
    w_wb_mem_to_reg = 1'b0;
    w_wb_rd         = '0;
    w_wb_alu_result = '0;
    w_wb_read_data  = '0;
    if (w_pass) begin
      w_wb_bubble     = 1'b0;
      w_wb_reg_write  = RegWrite_in;
      w_wb_mem_to_reg = MemtoReg_in;
      w_wb_rd         = EX_MEM_RegisterRd_in;
      w_wb_alu_result = ALU_result_in;
    end else if (w_ack) begin
      w_wb_bubble     = 1'b0;
      w_wb_reg_write  = r_cap_reg_write;
      w_wb_mem_to_reg = r_cap_mem_to_reg;
      w_wb_rd         = r_cap_rd;
      w_wb_alu_result = r_mem_addr;
      w_wb_read_data  = r_mem_we ? 32'd0 : mem_rdata;
    end
  end

  mem_wb_reg u_mem_wb_reg (
    .clk          (clk),
    .reset        (reset),
    .i_bubble     (w_wb_bubble),
    .i_reg_write  (w_wb_reg_write),
    .i_mem_to_reg (w_wb_mem_to_reg),
    .i_rd         (w_wb_rd),
    .i_alu_result (w_wb_alu_result),
    .i_read_data  (w_wb_read_data),
    .o_reg_write  (RegWrite_out),
    .o_mem_to_reg (MemtoReg_out),
    .o_rd         (MEM_WB_RegisterRd_out),
    .o_alu_result (ALU_result_out),
    .o_read_data  (mem_read_data_out)
  );

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_err   = r_mem_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed table, reset corner case,
// and randomized instructions checked against a transaction-level model.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in;
  logic [31:0] ALU_result_in, reg_read_data_2_in;
  logic [4:0]  EX_MEM_RegisterRd_in;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_req, mem_we, MEM_Stall, mem_err;
  logic [31:0] mem_addr, mem_wdata;
  logic        RegWrite_out, MemtoReg_out;
  logic [31:0] mem_read_data_out, ALU_result_out;
  logic [4:0]  MEM_WB_RegisterRd_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ACK_TIMEOUT(TO)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .RegWrite_in           (RegWrite_in),
    .MemtoReg_in           (MemtoReg_in),
    .MemRead_in            (MemRead_in),
    .MemWrite_in           (MemWrite_in),
    .ALU_result_in         (ALU_result_in),
    .reg_read_data_2_in    (reg_read_data_2_in),
    .EX_MEM_RegisterRd_in  (EX_MEM_RegisterRd_in),
    .mem_ack               (mem_ack),
    .mem_rdata             (mem_rdata),
    .mem_req               (mem_req),
    .mem_we                (mem_we),
    .mem_addr              (mem_addr),
    .mem_wdata             (mem_wdata),
    .MEM_Stall             (MEM_Stall),
    .mem_err               (mem_err),
    .RegWrite_out          (RegWrite_out),
    .MemtoReg_out          (MemtoReg_out),
    .mem_read_data_out     (mem_read_data_out),
    .ALU_result_out        (ALU_result_out),
    .MEM_WB_RegisterRd_out (MEM_WB_RegisterRd_out)
  );

  // One instruction: inputs, memory behaviour, and the expected outcome.
  typedef struct {
    logic        rw, mtr, mr, mw;
    logic [31:0] alu, wdata, rdata;
    logic [4:0]  rd;
    int          ack_lat;   // BUSY cycles without ack before the ack cycle
    int          e_stall;   // total cycles with MEM_Stall=1
    logic        e_err, e_we, e_rw, e_mtr;
    logic [4:0]  e_rd;
    logic [31:0] e_alu, e_rdata;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic rw, input logic mtr, input logic mr, input logic mw,
    input logic [31:0] alu, input logic [31:0] wdata, input logic [4:0] rd,
    input int ack_lat, input logic [31:0] rdata,
    input int e_stall, input logic e_err, input logic e_we,
    input logic e_rw, input logic e_mtr, input logic [4:0] e_rd,
    input logic [31:0] e_alu, input logic [31:0] e_rdata);
    vec_t v;
    v.rw = rw; v.mtr = mtr; v.mr = mr; v.mw = mw;
    v.alu = alu; v.wdata = wdata; v.rd = rd; v.ack_lat = ack_lat; v.rdata = rdata;
    v.e_stall = e_stall; v.e_err = e_err; v.e_we = e_we;
    v.e_rw = e_rw; v.e_mtr = e_mtr; v.e_rd = e_rd; v.e_alu = e_alu; v.e_rdata = e_rdata;
    return v;
  endfunction

  // Transaction-level reference: outcome of one instruction from the access rules.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    bit   access = (v.mr | v.mw);
    r.e_we = v.mw;
    r.e_rw = 1'b0; r.e_mtr = 1'b0; r.e_rd = '0; r.e_alu = '0; r.e_rdata = '0;
    if (!access) begin
      r.e_stall = 0; r.e_err = 1'b0;
      r.e_rw = v.rw; r.e_mtr = v.mtr; r.e_rd = v.rd; r.e_alu = v.alu;
    end else if ((v.alu % 4) != 0) begin
      r.e_stall = 0; r.e_err = 1'b1;
    end else if (v.ack_lat < TO) begin
      r.e_stall = v.ack_lat + 1; r.e_err = 1'b0;
      r.e_rw = v.rw; r.e_mtr = v.mtr; r.e_rd = v.rd; r.e_alu = v.alu;
      r.e_rdata = v.mw ? 32'd0 : v.rdata;
    end else begin
      r.e_stall = TO; r.e_err = 1'b1;
    end
    return r;
  endfunction

  task automatic drive_idle();
    RegWrite_in = 1'b0; MemtoReg_in = 1'b0; MemRead_in = 1'b0; MemWrite_in = 1'b0;
    ALU_result_in = '0; reg_read_data_2_in = '0; EX_MEM_RegisterRd_in = '0;
    mem_ack = 1'b0; mem_rdata = '0;
  endtask

  // Apply one instruction, play the memory side, and check the outcome.
  task automatic run_vec(input vec_t v, input string tag);
    int stalls = 0;
    bit done = 1'b0;
    int k = 0;
    @(negedge clk);
    RegWrite_in = v.rw; MemtoReg_in = v.mtr; MemRead_in = v.mr; MemWrite_in = v.mw;
    ALU_result_in = v.alu; reg_read_data_2_in = v.wdata; EX_MEM_RegisterRd_in = v.rd;
    mem_ack = 1'($urandom_range(0, 1));   // must be ignored while IDLE
    mem_rdata = $urandom;
    #1;
    if (MEM_Stall) stalls++;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    if ((v.mr | v.mw) && ((v.alu % 4) == 0)) begin
      chk({tag, ".req_up"}, 32'(mem_req), 32'd1);
      chk({tag, ".we"}, 32'(mem_we), 32'(v.e_we));
      chk({tag, ".addr"}, mem_addr, v.alu);
      chk({tag, ".wdata"}, mem_wdata, v.wdata);
      chk({tag, ".entry_err"}, 32'(mem_err), 32'd0);
      chk({tag, ".entry_bubble"}, {26'd0, RegWrite_out, MEM_WB_RegisterRd_out}, 32'd0);
      while (!done && k < 40) begin
        @(negedge clk);
        mem_ack = (k == v.ack_lat);
        mem_rdata = (k == v.ack_lat) ? v.rdata : $urandom;
        #1;
        if (MEM_Stall) stalls++;
        tests++;
        if (!(mem_req === 1'b1 && mem_addr === v.alu && mem_wdata === v.wdata && mem_we === v.e_we)) begin
          fails++;
          $display("FAIL %s.hold: req=%0b we=%0b addr=0x%08h wdata=0x%08h, expected req=1 we=%0b addr=0x%08h wdata=0x%08h",
                   tag, mem_req, mem_we, mem_addr, mem_wdata, v.e_we, v.alu, v.wdata);
        end
        done = !MEM_Stall;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        k++;
      end
      if (!done) begin
        tests++; fails++;
        $display("FAIL %s.release: stall still 1 after %0d BUSY cycles, expected release", tag, k);
      end
    end
    chk({tag, ".stall_cycles"}, 32'(stalls), 32'(v.e_stall));
    chk({tag, ".req_down"}, 32'(mem_req), 32'd0);
    chk({tag, ".err"}, 32'(mem_err), 32'(v.e_err));
    chk({tag, ".regwrite"}, 32'(RegWrite_out), 32'(v.e_rw));
    chk({tag, ".memtoreg"}, 32'(MemtoReg_out), 32'(v.e_mtr));
    chk({tag, ".rd"}, 32'(MEM_WB_RegisterRd_out), 32'(v.e_rd));
    if (!v.e_err) begin
      chk({tag, ".alu_out"}, ALU_result_out, v.e_alu);
      chk({tag, ".rdata_out"}, mem_read_data_out, v.e_rdata);
    end
    $display("[TB] %s rd/mr/mw=%0b%0b addr=0x%08h ack_lat=%0d stalls=%0d err=%0b wb_rd=%0d",
             tag, v.mr, v.mw, v.alu, v.ack_lat, stalls, mem_err, MEM_WB_RegisterRd_out);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    int   sel;

    // Directed table: {inputs, memory latency} -> expected outcome.
    vecs[0] = mk(1,0,0,0, 32'h0000_1234, 32'h0,         5,  0, 32'h0,         0,0,0, 1,0,5,  32'h0000_1234, 32'h0);
    vecs[1] = mk(1,1,1,0, 32'h0000_0100, 32'h0BAD_0BAD, 7,  1, 32'hDEAD_BEEF, 2,0,0, 1,1,7,  32'h0000_0100, 32'hDEAD_BEEF);
    vecs[2] = mk(0,0,0,1, 32'h0000_0200, 32'hA5A5_A5A5, 9,  3, 32'h7777_7777, 4,0,1, 0,0,9,  32'h0000_0200, 32'h0);
    vecs[3] = mk(1,1,1,0, 32'h0000_0104, 32'h0,         4, 99, 32'h0,         4,1,0, 0,0,0,  32'h0,         32'h0);
    vecs[4] = mk(1,1,1,0, 32'h0000_0108, 32'h0,         6,  3, 32'h1357_9BDF, 4,0,0, 1,1,6,  32'h0000_0108, 32'h1357_9BDF);
    vecs[5] = mk(1,1,1,0, 32'h0000_0102, 32'h0,         3,  0, 32'h0,         0,1,0, 0,0,0,  32'h0,         32'h0);
    vecs[6] = mk(1,0,1,1, 32'h0000_0300, 32'h1122_3344, 8,  0, 32'h9999_9999, 1,0,1, 1,0,8,  32'h0000_0300, 32'h0);
    vecs[7] = mk(0,0,0,1, 32'h0000_0203, 32'h5,         2,  0, 32'h0,         0,1,1, 0,0,0,  32'h0,         32'h0);
    vecs[8] = mk(1,1,1,0, 32'hFFFF_FFFC, 32'h0,        31,  0, 32'hCAFE_F00D, 1,0,0, 1,1,31, 32'hFFFF_FFFC, 32'hCAFE_F00D);
    vecs[9] = mk(0,1,0,0, 32'hFFFF_FFFF, 32'h0,        17,  0, 32'h0,         0,0,0, 0,1,17, 32'hFFFF_FFFF, 32'h0);

    // Reset with an aligned access presented: no stall, everything cleared.
    drive_idle();
    reset = 1'b0;
    MemRead_in = 1'b1; ALU_result_in = 32'h40; RegWrite_in = 1'b1; EX_MEM_RegisterRd_in = 5'd4;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.stall", 32'(MEM_Stall), 32'd0);
    chk("rst.req_we_err", {29'd0, mem_req, mem_we, mem_err}, 32'd0);
    chk("rst.addr", mem_addr, 32'd0);
    chk("rst.wdata", mem_wdata, 32'd0);
    chk("rst.wb_ctl", {25'd0, RegWrite_out, MemtoReg_out, MEM_WB_RegisterRd_out}, 32'd0);
    chk("rst.wb_data", ALU_result_out | mem_read_data_out, 32'd0);
    drive_idle();
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset asserted on the second BUSY cycle of a store abandons it silently.
    @(negedge clk);
    MemWrite_in = 1'b1; RegWrite_in = 1'b1; ALU_result_in = 32'h400;
    reg_read_data_2_in = 32'h55AA_55AA; EX_MEM_RegisterRd_in = 5'd12;
    @(posedge clk); #1;
    chk("midrst.req_up", 32'(mem_req), 32'd1);
    @(negedge clk);
    mem_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst.stall", 32'(MEM_Stall), 32'd0);
    @(posedge clk); #1;
    chk("midrst.req_we_err", {29'd0, mem_req, mem_we, mem_err}, 32'd0);
    chk("midrst.addr", mem_addr, 32'd0);
    chk("midrst.wdata", mem_wdata, 32'd0);
    chk("midrst.wb_ctl", {25'd0, RegWrite_out, MemtoReg_out, MEM_WB_RegisterRd_out}, 32'd0);
    chk("midrst.wb_data", ALU_result_out | mem_read_data_out, 32'd0);
    @(negedge clk);
    drive_idle();
    reset = 1'b1;
    // Back in IDLE: a plain ALU op must pass straight through.
    run_vec(model(mk(1,0,0,0, 32'h0000_5678, 32'h0, 11, 0, 32'h0, 0,0,0, 0,0,0, 32'h0, 32'h0)), "post_rst");

    // Randomized instruction stream against the reference model.
    for (int i = 0; i < 60; i++) begin
      v = mk(0,0,0,0, 32'h0, 32'h0, 5'd0, 0, 32'h0, 0,0,0, 0,0,5'd0, 32'h0, 32'h0);
      v.rw = 1'($urandom_range(0, 1));
      v.mtr = 1'($urandom_range(0, 1));
      v.rd = 5'($urandom_range(0, 31));
      v.wdata = $urandom;
      v.rdata = $urandom;
      v.ack_lat = $urandom_range(0, TO + 1);
      sel = $urandom_range(0, 9);
      if (sel < 2) begin
        v.alu = $urandom;
      end else begin
        sel = $urandom_range(1, 3);
        v.mr = sel[0];
        v.mw = sel[1];
        v.alu = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 4) == 0) v.alu = v.alu | 32'($urandom_range(1, 3));
      end
      run_vec(model(v), $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
